// File: rtl/d_npc_pc_pkg.sv
// Shared encodings for the fetch-PC / next-PC block.
// Holds the D-stage compare codes, the next-PC selector codes and the PC state machine states.
package d_npc_pc_pkg;

    localparam logic [2:0] CMP_EQ  = 3'd0;
    localparam logic [2:0] CMP_NE  = 3'd1;
    localparam logic [2:0] CMP_LEZ = 3'd2;
    localparam logic [2:0] CMP_GTZ = 3'd3;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_BR  = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } npc_state_e;

endpackage

// File: rtl/d_npc_calc.sv
// Combinational next-PC target selection and fetch-range legality check.
// Holds no state. The owning PC register decides whether the result is used.
module d_npc_calc
    import d_npc_pc_pkg::*;
#(
    parameter logic [31:0] PC_LO = 32'h0000_3000,
    parameter logic [31:0] PC_HI = 32'h0000_6FFC
) (
    input  logic [31:0] f_pc_i,
    input  logic [2:0]  npc_op_i,
    input  logic        zerocheck_i,
    input  logic [31:0] d_pc_i,
    input  logic [15:0] d_imm16_i,
    input  logic [25:0] d_imm26_i,
    input  logic [31:0] d_rs_i,
    output logic [31:0] npc_o,
    output logic        taken_o,
    output logic        illegal_o
);

    logic        [31:0] pc4;
    logic signed [31:0] br_off;
    logic        [31:0] br_tgt;

    assign pc4    = f_pc_i + 32'd4;
    assign br_off = $signed({{14{d_imm16_i[15]}}, d_imm16_i, 2'b00});
    // Branch offset is relative to the delay-slot address, D_PC+4.
    assign br_tgt = d_pc_i + 32'd4 + $unsigned(br_off);

    always_comb begin
        npc_o   = pc4;
        taken_o = 1'b0;
        case (npc_op_i)
            NPC_BR: begin
                if (zerocheck_i) begin
                    npc_o   = br_tgt;
                    taken_o = 1'b1;
                end
            end
            NPC_J: begin
                npc_o   = {d_pc_i[31:28], d_imm26_i, 2'b00};
                taken_o = 1'b1;
            end
            NPC_JR: begin
                npc_o   = d_rs_i;
                taken_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_o = (npc_o[1:0] != 2'b00) || (npc_o < PC_LO) || (npc_o > PC_HI);

endmodule

// File: rtl/d_npc_pc.sv
// Fetch-PC register with BOOT/RUN/FAULT control and next-PC redirect from the D stage.
// Optional macro NPC_PERF_EN adds saturating taken-branch, stall and jr-redirect counters.
module d_npc_pc
    import d_npc_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  NPCOp,
    input  logic        zerocheck,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs,
    output logic [31:0] F_PC,
    output logic        F_valid,
    output logic        redirect,
    output logic        fault,
    output logic [31:0] fault_pc
`ifdef NPC_PERF_EN
    ,
    output logic [31:0] perf_taken,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_redirect_jr
`endif
);

    npc_state_e  state_q, state_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic [31:0] npc;
    logic        taken;
    logic        illegal;

    d_npc_calc #(
        .PC_LO (PC_LO),
        .PC_HI (PC_HI)
    ) u_calc (
        .f_pc_i      (f_pc_q),
        .npc_op_i    (NPCOp),
        .zerocheck_i (zerocheck),
        .d_pc_i      (D_PC),
        .d_imm16_i   (D_imm16),
        .d_imm26_i   (D_imm26),
        .d_rs_i      (D_rs),
        .npc_o       (npc),
        .taken_o     (taken),
        .illegal_o   (illegal)
    );

    always_comb begin
        state_d    = state_q;
        f_pc_d     = f_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                // A stalled D stage re-presents the same decision, so nothing is evaluated.
                if (!stall) begin
                    if (illegal) begin
                        state_d    = S_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = npc;
                    end else begin
                        f_pc_d = npc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_BOOT;
            f_pc_q     <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            f_pc_q     <= f_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign F_PC     = f_pc_q;
    assign F_valid  = (state_q == S_RUN);
    assign redirect = (state_q == S_RUN) && !stall && taken;
    assign fault    = fault_q;
    assign fault_pc = fault_pc_q;

`ifdef NPC_PERF_EN
    logic [31:0] perf_taken_q, perf_stall_q, perf_jr_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_taken_q <= 32'd0;
            perf_stall_q <= 32'd0;
            perf_jr_q    <= 32'd0;
        end else if (state_q != S_FAULT) begin
            if (redirect && NPCOp == NPC_BR) perf_taken_q <= sat_inc(perf_taken_q);
            if (state_q == S_RUN && stall)   perf_stall_q <= sat_inc(perf_stall_q);
            if (redirect && NPCOp == NPC_JR) perf_jr_q    <= sat_inc(perf_jr_q);
        end
    end

    assign perf_taken       = perf_taken_q;
    assign perf_stall       = perf_stall_q;
    assign perf_redirect_jr = perf_jr_q;
`endif

endmodule
